// File: rtl/midisynth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midisynth_pkg
//  Description : Shared constants, parser state enum and pitch-table helper
//                for the MIDI note controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package midisynth_pkg;

  // Channel-voice status nibbles (upper four bits of a status byte)
  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] POLY_AT    = 4'hA;
  localparam logic [3:0] CTRL_CHG   = 4'hB;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_AT    = 4'hD;
  localparam logic [3:0] PITCH_BEND = 4'hE;

  // Bytes at or above these values are system-common / real-time
  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA1 = 2'd1,
    ST_DATA2 = 2'd2,
    ST_SKIP  = 2'd3
  } parser_state_e;

  // Program change and channel aftertouch carry a single data byte
  function automatic logic one_data_byte(input logic [3:0] kind);
    return (kind == PROG_CHG) || (kind == CHAN_AT);
  endfunction

  // Phase increment of semitone k in the top octave (notes 120..131),
  // rounded to nearest; lower octaves are derived by right shifts.
  function automatic logic [31:0] pitch_entry(input int k, input int unsigned clk_hz);
    real freq;
    real inc;
    freq = 440.0 * (2.0 ** (real'(51 + k) / 12.0));
    inc  = freq * 4294967296.0 / real'(clk_hz);
    return $rtoi(inc + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/midi_pitch_rom.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pitch_rom
//  Description : MIDI note number to DDS phase increment. Twelve-entry
//                top-octave table, shifted right by octave, registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_pitch_rom
  import midisynth_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [6:0]  note_i,
  output logic [31:0] delta_phase_o
);

  logic [31:0] w_table [12];
  logic [31:0] w_entry;
  logic [6:0]  w_octave;
  logic [6:0]  w_semitone;
  logic [6:0]  w_shift;
  logic [31:0] delta_q;

  for (genvar k = 0; k < 12; k++) begin : g_table
    localparam logic [31:0] ENTRY = pitch_entry(k, CLK_HZ);
    assign w_table[k] = ENTRY;
  end

  assign w_octave   = note_i / 7'd12;
  assign w_semitone = note_i % 7'd12;
  assign w_shift    = 7'd10 - w_octave;

  // Select the table entry for the semitone within the octave
  always_comb begin
    w_entry = w_table[0];
    for (int k = 1; k < 12; k++) begin
      if (w_semitone == 7'(k)) w_entry = w_table[k];
    end
  end

  // Register the increment only when a new pitch is loaded; hold otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      delta_q <= '0;
    end else if (load_i) begin
      delta_q <= w_entry >> w_shift;
    end
  end

  assign delta_phase_o = delta_q;

endmodule
`default_nettype wire

// File: rtl/midi_note_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : midi_note_ctrl
//  Description : Monophonic MIDI channel-voice decoder driving one DDS/ADSR
//                voice (gate, note, velocity, phase increment).
//                Last-note priority; note-off only releases the sounding note.
//                Optional macro MIDI_RUNNING_STATUS_EN keeps the status byte
//                after each completed message (running status).
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_note_ctrl
  import midisynth_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter logic [3:0]  MIDI_CHANNEL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        key_state,
  output logic [6:0]  note,
  output logic [6:0]  velocity,
  output logic [31:0] delta_phase,
  output logic        note_event
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam parser_state_e AFTER_MSG = ST_DATA1;
`else
  localparam parser_state_e AFTER_MSG = ST_IDLE;
`endif

  parser_state_e state_q;
  logic [7:0]    status_q;
  logic [6:0]    d1_q;
  logic          msg_valid_q;
  logic [3:0]    msg_kind_q;
  logic [3:0]    msg_chan_q;
  logic [6:0]    msg_d1_q;
  logic [6:0]    msg_d2_q;

  logic          key_q;
  logic [6:0]    note_q;
  logic [6:0]    velocity_q;
  logic          event_q;

  logic          w_for_us;
  logic          w_note_on;
  logic          w_note_off;

  // Byte parser: assembles channel messages, emits one registered message strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      status_q    <= '0;
      d1_q        <= '0;
      msg_valid_q <= 1'b0;
      msg_kind_q  <= '0;
      msg_chan_q  <= '0;
      msg_d1_q    <= '0;
      msg_d2_q    <= '0;
    end else begin
      msg_valid_q <= 1'b0;
      if (rx_valid) begin
        if (rx_data >= REALTIME_MIN) begin
          // real-time bytes are transparent to the parser
        end else if (rx_data >= SYS_COMMON_MIN) begin
          status_q <= '0;
          state_q  <= ST_SKIP;
        end else if (rx_data[7]) begin
          status_q <= rx_data;
          state_q  <= ST_DATA1;
        end else begin
          case (state_q)
            ST_DATA1: begin
              d1_q <= rx_data[6:0];
              if (one_data_byte(status_q[7:4])) begin
                msg_valid_q <= 1'b1;
                msg_kind_q  <= status_q[7:4];
                msg_chan_q  <= status_q[3:0];
                msg_d1_q    <= rx_data[6:0];
                msg_d2_q    <= '0;
                state_q     <= AFTER_MSG;
              end else begin
                state_q <= ST_DATA2;
              end
            end
            ST_DATA2: begin
              msg_valid_q <= 1'b1;
              msg_kind_q  <= status_q[7:4];
              msg_chan_q  <= status_q[3:0];
              msg_d1_q    <= d1_q;
              msg_d2_q    <= rx_data[6:0];
              state_q     <= AFTER_MSG;
            end
            default: begin
              // data in IDLE or SKIP has no status to attach to
            end
          endcase
        end
      end
    end
  end

  assign w_for_us   = msg_valid_q && (msg_chan_q == MIDI_CHANNEL);
  assign w_note_on  = w_for_us && (msg_kind_q == NOTE_ON) && (msg_d2_q != 7'd0);
  assign w_note_off = w_for_us &&
                      ((msg_kind_q == NOTE_OFF) ||
                       ((msg_kind_q == NOTE_ON) && (msg_d2_q == 7'd0)));

  // Voice state: note-on always wins, note-off releases only the sounding note
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q      <= 1'b0;
      note_q     <= '0;
      velocity_q <= '0;
      event_q    <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (w_note_on) begin
        key_q      <= 1'b1;
        note_q     <= msg_d1_q;
        velocity_q <= msg_d2_q;
        event_q    <= 1'b1;
      end else if (w_note_off && key_q && (msg_d1_q == note_q)) begin
        key_q   <= 1'b0;
        event_q <= 1'b1;
      end
    end
  end

  // Pitch register updates on the same edge as note/gate
  midi_pitch_rom #(
    .CLK_HZ (CLK_HZ)
  ) u_pitch_rom (
    .clk           (clk),
    .reset         (reset),
    .load_i        (w_note_on),
    .note_i        (msg_d1_q),
    .delta_phase_o (delta_phase)
  );

  assign key_state  = key_q;
  assign note       = note_q;
  assign velocity   = velocity_q;
  assign note_event = event_q;

endmodule
`default_nettype wire

// File: tb/tb_midi_note_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_note_ctrl
//  Description : Self-checking bench for midi_note_ctrl with a message-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_note_ctrl;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int          CHAN   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        key_state;
  logic [6:0]  note;
  logic [6:0]  velocity;
  logic [31:0] delta_phase;
  logic        note_event;

  always #5 clk = ~clk;

  midi_note_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .MIDI_CHANNEL (4'(CHAN))
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .key_state   (key_state),
    .note        (note),
    .velocity    (velocity),
    .delta_phase (delta_phase),
    .note_event  (note_event)
  );

  int errors = 0;
  int checks = 0;
  int ev_cnt = 0;

  always @(negedge clk) if (note_event === 1'b1) ev_cnt++;

  // ---------------- reference model ----------------
  logic [31:0] ref_table [12];
  int          m_status;
  int          m_cnt;
  int          m_d1;
  logic        m_key;
  logic [6:0]  m_note;
  logic [6:0]  m_vel;
  logic [31:0] m_delta;
  int          m_events = 0;

  function automatic logic [31:0] ref_pitch(input int n);
    return ref_table[n % 12] >> (10 - n / 12);
  endfunction

  task automatic model_reset();
    m_status = -1;
    m_cnt    = 0;
    m_key    = 1'b0;
    m_note   = '0;
    m_vel    = '0;
    m_delta  = '0;
  endtask

  task automatic model_msg(input int st, input int d1, input int d2);
    int typ;
    typ = (st >> 4) & 15;
    if ((st & 15) != CHAN) return;
    if (typ == 9 && d2 != 0) begin
      m_key   = 1'b1;
      m_note  = 7'(d1);
      m_vel   = 7'(d2);
      m_delta = ref_pitch(d1);
      m_events++;
    end else if ((typ == 8 || typ == 9) && m_key && d1 == int'(m_note)) begin
      m_key = 1'b0;
      m_events++;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int typ;
    int need;
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      m_status = -1;
      return;
    end
    if (b[7]) begin
      m_status = int'(b);
      m_cnt    = 0;
      return;
    end
    if (m_status < 0) return;
    typ  = (m_status >> 4) & 15;
    need = (typ == 12 || typ == 13) ? 1 : 2;
    if (m_cnt == 0) m_d1 = int'(b);
    m_cnt++;
    if (m_cnt == need) begin
      model_msg(m_status, m_d1, (need == 2) ? int'(b) : 0);
      m_cnt = 0;
`ifndef MIDI_RUNNING_STATUS_EN
      m_status = -1;
`endif
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    idle(1);
    checks++;
    if ({key_state, note, velocity, delta_phase, note_event} !== 47'd0) begin
      errors++;
      $display("FAIL reset_state: got key=%b note=%0d vel=%0d dp=%0d ev=%b, expected all zero",
               key_state, note, velocity, delta_phase, note_event);
    end
  endtask

  task automatic test_basic_note_on();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    send(8'h90); send(8'h45); send(8'h64);
    @(negedge clk); rx_valid = 1'b0;
    checks++;
    if (note_event !== 1'b0 || key_state !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got ev=%b key=%b one cycle after last byte, expected 0 0",
               note_event, key_state);
    end
    @(negedge clk);
    checks++;
    if ({note_event, key_state, note, velocity, delta_phase} !== {1'b1, 1'b1, 7'd69, 7'd100, 32'd37795}) begin
      errors++;
      $display("FAIL basic_note_on: got ev=%b key=%b note=%0d vel=%0d dp=%0d, expected 1 1 69 100 37795",
               note_event, key_state, note, velocity, delta_phase);
    end
    @(negedge clk);
    checks++;
    if (note_event !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: got ev=%b, expected 0", note_event);
    end
    idle(2);
    checks++;
    if (ev_cnt - ev0 != 1) begin
      errors++;
      $display("FAIL basic_event_count: got %0d, expected 1", ev_cnt - ev0);
    end
  endtask

  task automatic test_note_matching();
    // continues from the sounding note 69
    send(8'h40); send(8'h00); idle(3);
    checks++;
    if ({key_state, note, delta_phase} !== {1'b1, 7'd69, 32'd37795}) begin
      errors++;
      $display("FAIL off_nonmatching: got key=%b note=%0d dp=%0d, expected 1 69 37795",
               key_state, note, delta_phase);
    end
    send(8'h45); send(8'h00); idle(3);
`ifdef MIDI_RUNNING_STATUS_EN
    checks++;
    if ({key_state, note, delta_phase} !== {1'b0, 7'd69, 32'd37795}) begin
      errors++;
      $display("FAIL off_running: got key=%b note=%0d dp=%0d, expected 0 69 37795",
               key_state, note, delta_phase);
    end
`else
    checks++;
    if (key_state !== 1'b1) begin
      errors++;
      $display("FAIL off_no_status: got key=%b, expected 1", key_state);
    end
`endif
    send(8'h80); send(8'h45); send(8'h10); idle(3);
    checks++;
    if ({key_state, note, velocity, delta_phase} !== {1'b0, 7'd69, 7'd100, 32'd37795}) begin
      errors++;
      $display("FAIL off_explicit: got key=%b note=%0d vel=%0d dp=%0d, expected 0 69 100 37795",
               key_state, note, velocity, delta_phase);
    end
  endtask

  task automatic test_realtime();
    do_reset();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h7F); idle(3);
    checks++;
    if ({key_state, note, velocity, delta_phase} !== {1'b1, 7'd60, 7'd127, ref_table[0] >> 5}) begin
      errors++;
      $display("FAIL realtime: got key=%b note=%0d vel=%0d dp=%0d, expected 1 60 127 %0d",
               key_state, note, velocity, delta_phase, ref_table[0] >> 5);
    end
    checks++;
    if (delta_phase !== 32'd22473) begin
      errors++;
      $display("FAIL realtime_c4_pitch: got %0d, expected 22473", delta_phase);
    end
  endtask

  task automatic test_filtering();
    do_reset();
    send(8'h90); send(8'h45); send(8'h64); idle(3);
    send(8'h91); send(8'h45); send(8'h00); idle(3);
    send(8'h91); send(8'h40); send(8'h64); idle(3);
    send(8'hB0); send(8'h07); send(8'h7F); idle(3);
    checks++;
    if ({key_state, note, velocity} !== {1'b1, 7'd69, 7'd100}) begin
      errors++;
      $display("FAIL filter_ignored: got key=%b note=%0d vel=%0d, expected 1 69 100",
               key_state, note, velocity);
    end
    send(8'hC0); send(8'h05); send(8'h90); send(8'h30); send(8'h10); idle(3);
    checks++;
    if ({key_state, note, velocity, delta_phase} !== {1'b1, 7'd48, 7'd16, ref_pitch(48)}) begin
      errors++;
      $display("FAIL filter_after_pc: got key=%b note=%0d vel=%0d dp=%0d, expected 1 48 16 %0d",
               key_state, note, velocity, delta_phase, ref_pitch(48));
    end
  endtask

  task automatic test_reset_mid_message();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    send(8'h90); send(8'h45);
    @(negedge clk); rx_valid = 1'b0; reset = 1'b0;
    @(negedge clk); reset = 1'b1; model_reset();
    send(8'h64); idle(3);
    checks++;
    if ({key_state, note, velocity, delta_phase} !== 46'd0 || ev_cnt != ev0) begin
      errors++;
      $display("FAIL reset_mid_msg: got key=%b note=%0d vel=%0d dp=%0d events=%0d, expected zeros and 0 events",
               key_state, note, velocity, delta_phase, ev_cnt - ev0);
    end
  endtask

  task automatic test_reset_pending();
    int ev0;
    int saved;
    do_reset();
    ev0 = ev_cnt;
    send(8'h90); send(8'h45);
    saved = m_events;
    send(8'h64);
    @(negedge clk); rx_valid = 1'b0; reset = 1'b0;
    @(negedge clk); reset = 1'b1; model_reset();
    m_events = saved;  // the in-flight update is dropped by the reset
    idle(3);
    checks++;
    if ({key_state, note, velocity, delta_phase} !== 46'd0 || ev_cnt != ev0) begin
      errors++;
      $display("FAIL reset_pending: got key=%b note=%0d vel=%0d dp=%0d events=%0d, expected zeros and 0 events",
               key_state, note, velocity, delta_phase, ev_cnt - ev0);
    end
  endtask

  task automatic test_running_status();
    do_reset();
    send(8'h90); send(8'h45); send(8'h64); send(8'h46); send(8'h64); idle(3);
`ifdef MIDI_RUNNING_STATUS_EN
    checks++;
    if ({key_state, note, delta_phase} !== {1'b1, 7'd70, ref_pitch(70)}) begin
      errors++;
      $display("FAIL running_status: got key=%b note=%0d dp=%0d, expected 1 70 %0d",
               key_state, note, delta_phase, ref_pitch(70));
    end
`else
    checks++;
    if ({key_state, note, delta_phase} !== {1'b1, 7'd69, 32'd37795}) begin
      errors++;
      $display("FAIL no_running_status: got key=%b note=%0d dp=%0d, expected 1 69 37795",
               key_state, note, delta_phase);
    end
`endif
  endtask

  task automatic test_same_note();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    send(8'h90); send(8'h45); send(8'h64);
    send(8'h90); send(8'h45); send(8'h20); idle(3);
    checks++;
    if ({key_state, note, velocity} !== {1'b1, 7'd69, 7'd32} || ev_cnt - ev0 != 2) begin
      errors++;
      $display("FAIL same_note: got key=%b note=%0d vel=%0d events=%0d, expected 1 69 32 2",
               key_state, note, velocity, ev_cnt - ev0);
    end
  endtask

  task automatic test_back_to_back();
    int ev0;
    do_reset();
    ev0 = ev_cnt;
    send(8'h90); send(8'h3C); send(8'h40);
    send(8'h90); send(8'h3E); send(8'h41);
    send(8'h80); send(8'h3E); send(8'h00);
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({note_event, key_state, note} !== {1'b1, 1'b0, 7'd62}) begin
      errors++;
      $display("FAIL back_to_back_last: got ev=%b key=%b note=%0d, expected 1 0 62",
               note_event, key_state, note);
    end
    idle(2);
    checks++;
    if (ev_cnt - ev0 != 3 || velocity !== 7'd65 || delta_phase !== ref_pitch(62)) begin
      errors++;
      $display("FAIL back_to_back: got events=%0d vel=%0d dp=%0d, expected 3 65 %0d",
               ev_cnt - ev0, velocity, delta_phase, ref_pitch(62));
    end
  endtask

  task automatic test_random();
    logic [7:0] st_list [8];
    logic [7:0] sys_list [5];
    logic [7:0] b;
    int ev0;
    int len;
    int r;
    st_list  = '{8'h90, 8'h90, 8'h80, 8'h91, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
    sys_list = '{8'hF0, 8'hF7, 8'hF8, 8'hFE, 8'hF2};
    do_reset();
    ev0 = ev_cnt - m_events;
    for (int burst = 0; burst < 60; burst++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r < 3)       b = st_list[$urandom_range(0, 7)];
        else if (r == 3) b = sys_list[$urandom_range(0, 4)];
        else if (r < 7)  b = 8'(8'h3C + $urandom_range(0, 3));
        else if (r == 7) b = 8'h00;
        else             b = 8'($urandom_range(0, 127));
        send(b);
      end
      idle(3);
      checks++;
      if ({key_state, note, velocity, delta_phase} !== {m_key, m_note, m_vel, m_delta}) begin
        errors++;
        $display("FAIL random_outputs[%0d]: got key=%b note=%0d vel=%0d dp=%0d, expected %b %0d %0d %0d",
                 burst, key_state, note, velocity, delta_phase, m_key, m_note, m_vel, m_delta);
      end
      checks++;
      if (ev_cnt - ev0 != m_events) begin
        errors++;
        $display("FAIL random_events[%0d]: got %0d, expected %0d", burst, ev_cnt - ev0, m_events);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 12; k++) begin
      real f;
      f = 440.0 * (2.0 ** ((51.0 + real'(k)) / 12.0));
      ref_table[k] = $rtoi(f * 4294967296.0 / real'(CLK_HZ) + 0.5);
    end
    model_reset();
    test_reset();
    test_basic_note_on();
    test_note_matching();
    test_realtime();
    test_filtering();
    test_reset_mid_message();
    test_reset_pending();
    test_running_status();
    test_same_note();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
